// File: rtl/intdiv_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// a counter-width helper that stays legal for tiny parameter values.
package intdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intdiv_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module intdiv_step #(
    parameter int LOGB = 43
) (
    input  logic [LOGB:0]   rem_i,
    input  logic            bit_i,
    input  logic [LOGB-1:0] div_i,
    output logic [LOGB:0]   rem_o,
    output logic            q_o
);

    logic [LOGB+1:0] shifted;
    logic [LOGB+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, div_i};
        q_o     = (shifted >= {2'b00, div_i});
        // rem_i < divisor, so the kept value always fits in LOGB+1 bits
        rem_o   = q_o ? (LOGB+1)'(diff) : (LOGB+1)'(shifted);
    end

endmodule

// File: rtl/intdiv_nonstd_seq.sv
// Sequential (LOGA+LOGB)/LOGB restoring divider producing a LOGA-bit quotient,
// with one-cycle divide-by-zero and quotient-overflow short paths.
module intdiv_nonstd_seq
    import intdiv_pkg::*;
#(
    parameter int LOGA = 34,
    parameter int LOGB = 43
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOGA+LOGB-1:0] C,
    input  logic [LOGB-1:0]      B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOGA-1:0]      Q,
    output logic [LOGB-1:0]      R,
    output logic                 dz,
    output logic                 ovf
);

    localparam int LAT  = LOGA + 1;
    localparam int CNTW = cnt_w(LAT - 1);

    state_t            state_q, state_d;
    logic [LOGB:0]     rem_q, rem_d;
    logic [LOGA-1:0]   q_q, q_d;
    logic [LOGB-1:0]   b_q, b_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;

    logic [LOGB-1:0]   c_hi;
    logic [LOGB:0]     step_rem;
    logic              step_q;

    assign c_hi = C[LOGA+LOGB-1:LOGA];

    // q_q doubles as the dividend low-part shifter: its MSB feeds the step,
    // and the new quotient bit enters at the LSB.
    intdiv_step #(.LOGB(LOGB)) u_step (
        .rem_i (rem_q),
        .bit_i (q_q[LOGA-1]),
        .div_i (b_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d   = B;
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                    if (B == '0) begin
                        dz_d    = 1'b1;
                        q_d     = '1;
                        rem_d   = {1'b0, C[LOGB-1:0]};
                        state_d = DONE;
                    end else if (c_hi >= B) begin
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        rem_d   = {1'b0, C[LOGB-1:0]};
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, c_hi};
                        q_d     = C[LOGA-1:0];
                        cnt_d   = CNTW'(LOGA - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                q_d   = (q_q << 1) | LOGA'(step_q);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = q_q;
    assign R         = rem_q[LOGB-1:0];
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_intdiv_nonstd_seq.sv
// Self-checking bench for intdiv_nonstd_seq: directed table, handshake and
// reset corner sequences, and random operands against an arithmetic model.
module tb_intdiv_nonstd_seq;

    localparam int LOGA = 34;
    localparam int LOGB = 43;
    localparam int CW   = LOGA + LOGB;
    localparam int LAT  = LOGA + 1;

    typedef struct packed {
        logic [LOGA-1:0] q;
        logic [LOGB-1:0] r;
        logic            dz;
        logic            ovf;
    } res_t;

    typedef struct {
        logic [CW-1:0]   c;
        logic [LOGB-1:0] b;
        res_t            exp;
        int              lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   c_in;
    logic [LOGB-1:0] b_in;
    logic            out_valid;
    logic            out_ready;
    logic [LOGA-1:0] q_out;
    logic [LOGB-1:0] r_out;
    logic            dz_out;
    logic            ovf_out;

    int checks   = 0;
    int failures = 0;

    intdiv_nonstd_seq #(.LOGA(LOGA), .LOGB(LOGB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (c_in),
        .B         (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (q_out),
        .R         (r_out),
        .dz        (dz_out),
        .ovf       (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division with the overflow rule stated on the
    // true quotient rather than on the dividend high part.
    function automatic res_t model(input logic [CW-1:0] c, input logic [LOGB-1:0] b, output int lat);
        res_t          r;
        logic [CW-1:0] qt;
        logic [CW-1:0] maxq;
        maxq = (CW'(1) << LOGA) - CW'(1);
        r    = '0;
        lat  = 1;
        if (b == '0) begin
            r.dz = 1'b1;
            r.q  = '1;
            r.r  = c[LOGB-1:0];
        end else begin
            qt = c / CW'(b);
            if (qt > maxq) begin
                r.ovf = 1'b1;
                r.q   = '1;
                r.r   = c[LOGB-1:0];
            end else begin
                r.q = LOGA'(qt);
                r.r = LOGB'(c % CW'(b));
                lat = LAT;
            end
        end
        return r;
    endfunction

    // Presents one operand (from a negedge), keeps in_valid high with junk
    // operands while busy, and measures acceptance-to-out_valid edges.
    task automatic run_op(input logic [CW-1:0] c, input logic [LOGB-1:0] b, input int hold,
                          output res_t got, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_op", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        c_in     = c;
        b_in     = b;
        @(negedge clk);
        c_in = ~c;
        b_in = ~b;
        lat  = 1;
        while (!out_valid && lat < LAT + 20) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        got.q   = q_out;
        got.r   = r_out;
        got.dz  = dz_out;
        got.ovf = ovf_out;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t tbl[5];

    initial begin
        res_t          got, exp;
        int            lat, elat;
        logic [CW-1:0] c;
        logic [LOGB-1:0] b;
        logic [LOGA-1:0] a;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_in      = '0;
        b_in      = '0;

        tbl[0] = '{c: CW'((CW'(1) << LOGA) - 1) * CW'((CW'(1) << LOGB) - 1),
                   b: '1, exp: '{q: '1, r: '0, dz: 1'b0, ovf: 1'b0}, lat: LAT};
        tbl[1] = '{c: CW'(1000), b: LOGB'(7), exp: '{q: LOGA'(142), r: LOGB'(6), dz: 1'b0, ovf: 1'b0}, lat: LAT};
        tbl[2] = '{c: CW'(0), b: LOGB'(1), exp: '{q: '0, r: '0, dz: 1'b0, ovf: 1'b0}, lat: LAT};
        tbl[3] = '{c: CW'(5), b: '0, exp: '{q: '1, r: LOGB'(5), dz: 1'b1, ovf: 1'b0}, lat: 1};
        tbl[4] = '{c: CW'(3) << LOGA, b: LOGB'(3), exp: '{q: '1, r: LOGB'(3) << LOGA, dz: 1'b0, ovf: 1'b1}, lat: 1};

        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_outputs", 128'({q_out, r_out, dz_out, ovf_out}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].c, tbl[i].b, i, got, lat);
            chk($sformatf("tbl%0d_q", i), 128'(got.q), 128'(tbl[i].exp.q));
            chk($sformatf("tbl%0d_r", i), 128'(got.r), 128'(tbl[i].exp.r));
            chk($sformatf("tbl%0d_flags", i), 128'({got.dz, got.ovf}), 128'({tbl[i].exp.dz, tbl[i].exp.ovf}));
            chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
        end

        // Result held in DONE while the consumer stalls; no accept on handoff edge.
        in_valid = 1'b1;
        c_in = CW'(1000);
        b_in = LOGB'(7);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LAT + 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 128'(lat), 128'(LAT));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_q", 128'(q_out), 128'(142));
            chk("hold_r", 128'(r_out), 128'(6));
            chk("hold_hs", 128'({out_valid, in_ready}), 128'(2'b10));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        c_in = CW'(77);
        b_in = LOGB'(1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("handoff_idle", 128'({out_valid, in_ready}), 128'(2'b01));

        // Reset pulsed in the middle of a normal-path operation.
        in_valid = 1'b1;
        c_in = CW'(123456789);
        b_in = LOGB'(97);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hs", 128'({out_valid, in_ready}), 128'(2'b01));
        chk("midrst_outputs", 128'({q_out, r_out, dz_out, ovf_out}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(CW'(1000), LOGB'(7), 0, got, lat);
        chk("postrst_q", 128'(got.q), 128'(142));
        chk("postrst_r", 128'(got.r), 128'(6));
        chk("postrst_lat", 128'(lat), 128'(LAT));

        // Exact products: quotient must come back as the multiplier.
        for (int i = 0; i < 15; i++) begin
            a = LOGA'({$urandom, $urandom});
            b = LOGB'({$urandom, $urandom});
            if (b == '0) b = LOGB'(1);
            c = CW'(a) * CW'(b);
            run_op(c, b, int'($urandom_range(0, 3)), got, lat);
            chk("prod_q", 128'(got.q), 128'(a));
            chk("prod_r", 128'(got.r), 128'(0));
            chk("prod_lat", 128'(lat), 128'(LAT));
        end

        // Arbitrary operands, mixing overflow, zero-divisor and normal cases.
        for (int i = 0; i < 25; i++) begin
            c = CW'({$urandom, $urandom, $urandom});
            b = LOGB'({$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) c = c >> $urandom_range(0, LOGB);
            if ($urandom_range(0, 9) == 0) b = '0;
            exp = model(c, b, elat);
            run_op(c, b, int'($urandom_range(0, 2)), got, lat);
            chk("rand_res", 128'(got), 128'(exp));
            chk("rand_lat", 128'(lat), 128'(elat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/intdiv_nonstd_seq.md
INTDIV_NONSTD_SEQ -- requirements
Module: intdiv_nonstd_seq

Interface
REQ-001 The block SHALL have parameter LOGA, default 34, quotient width in bits.
REQ-002 The block SHALL have parameter LOGB, default 43, divisor and remainder width in bits.
REQ-003 The block SHALL expose localparam LAT = LOGA+1, the normal-path latency in cycles.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  operand presented.
REQ-007 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-008 The block SHALL have port C  input  LOGA+LOGB  dividend (width matches the multiplier product).
REQ-009 The block SHALL have port B  input  LOGB  divisor.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 The block SHALL have port Q  output  LOGA  quotient.
REQ-013 The block SHALL have port R  output  LOGB  remainder.
REQ-014 The block SHALL have port dz  output  1  divisor was zero.
REQ-015 The block SHALL have port ovf  output  1  true quotient does not fit in LOGA bits.

Function
REQ-016 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Acceptance SHALL occur on a rising edge with in_valid=1 in IDLE; C and B SHALL be captured internally, and later input changes SHALL have no effect.
REQ-019 On acceptance with B=0: dz=1, ovf=0, Q=all ones, R=C[LOGB-1:0], next state DONE (1-cycle latency).
REQ-020 On acceptance with B!=0 and C[LOGA+LOGB-1:LOGA] >= B: ovf=1, dz=0, Q=all ones, R=C[LOGB-1:0], next state DONE (1-cycle latency).
REQ-021 Otherwise the block SHALL enter BUSY, with the partial remainder (LOGB+1 bits) initialised to C[LOGA+LOGB-1:LOGA] and the iteration counter set to LOGA-1.
REQ-022 Each BUSY cycle SHALL perform one restoring step, MSB first: shift the next C low-part bit into the remainder, trial-subtract B, keep the difference and set the Q bit when the difference is non-negative, else keep the shifted value and clear the Q bit.
REQ-023 BUSY SHALL last exactly LOGA cycles; on the counter reaching 0 the next state SHALL be DONE, so out_valid rises LAT edges after the acceptance edge.
REQ-024 In the normal path, results SHALL satisfy C = Q*B + R with R < B, and dz=ovf=0.
REQ-025 In DONE, Q, R, dz and ovf SHALL stay stable until the edge on which out_ready=1, which SHALL return the FSM to IDLE.
REQ-026 No new operand SHALL be accepted on the same edge as a result handoff.
REQ-027 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.

Reset
REQ-028 When rst_n=0, the block SHALL immediately enter IDLE with in_ready=1, out_valid=0, Q=0, R=0, dz=0, ovf=0 and the counter cleared, including when reset is asserted mid-BUSY or in DONE; any in-flight operation SHALL be discarded.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 FSM state encodings SHALL live in the shared package intdiv_pkg.
REQ-031 One combinational sub-module, intdiv_step (shift, trial subtract, quotient bit), SHALL be instantiated once.
REQ-032 The block SHALL use no DSP inference, with the datapath registers restricted to the remainder, quotient shift register, divisor and counter.

Verification
REQ-033 The bench SHALL check: C=(2^34-1)*(2^43-1), B=2^43-1 -> Q=2^34-1, R=0, dz=ovf=0, out_valid exactly LAT=35 cycles after acceptance.
REQ-034 The bench SHALL check: C=1000, B=7 -> Q=142, R=6; also C=0, B=1 -> Q=0, R=0.
REQ-035 The bench SHALL check: B=0, C=5 -> dz=1, Q=all ones, R=5, out_valid 1 cycle after acceptance.
REQ-036 The bench SHALL check: C=B<<34 with B=3 -> ovf=1, out_valid after 1 cycle; then random (A,B) with C=A*B -> Q=A, R=0.
REQ-037 The bench SHALL check: out_ready held low 10 cycles in DONE -> outputs constant and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 The bench SHALL check: rst_n pulsed low mid-BUSY -> out_valid=0 and in_ready=1 immediately; a new operation then completes correctly.
